mult_div_unit: RTL



---
 rtl/mult_div_unit_pkg.sv | 18 +
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared mult/div encodings and defaults.
// Imported by the MD unit, hazard unit and EX decode.
package md_defs;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam int HL_WE_HI = 1;
  localparam int HL_WE_LO = 0;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// In: clk, reset, start, md_op, src_a, src_b, hl_we, hl_wdata.
// Out: busy, hi, lo.
module mult_div_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  hl_we,
  input  logic [31:0] hl_wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_ok_q, pend_ok_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  md_op_e      op;
  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic        is_sdiv;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_ok;
  logic        is_div;

  assign op = md_op_e'(md_op);

  // Product and quotient are formed in the start cycle;
  // the busy period only models latency.
  always_comb begin
    mul_s = {{32{src_a[31]}}, src_a}
          * {{32{src_b[31]}}, src_b};
    mul_u = {32'b0, src_a} * {32'b0, src_b};

    is_sdiv = (op == MD_DIV);
    is_div  = (op == MD_DIV) || (op == MD_DIVU);
    a_neg   = is_sdiv & src_a[31];
    b_neg   = is_sdiv & src_b[31];

    // Signed divide on magnitudes; 0x80000000 stays
    // 0x80000000 as an unsigned magnitude, so the
    // overflow case needs no special handling.
    dvd      = a_neg ? -src_a : src_a;
    dvs      = b_neg ? -src_b : src_b;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    q_mag    = dvd / dvs_safe;
    r_mag    = dvd % dvs_safe;

    res_hi = 32'd0;
    res_lo = 32'd0;
    res_ok = 1'b1;
    unique case (op)
      MD_MULT: begin
        res_hi = mul_s[63:32];
        res_lo = mul_s[31:0];
      end
      MD_MULTU: begin
        res_hi = mul_u[63:32];
        res_lo = mul_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        res_hi = a_neg ? -r_mag : r_mag;
        // Zero divisor keeps HI/LO untouched.
        res_ok = (src_b != 32'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = is_div ? CW'(DIV_CYCLES)
                             : CW'(MULT_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_ok_d = res_ok;
        end else begin
          if (hl_we[HL_WE_HI]) hi_d = hl_wdata;
          if (hl_we[HL_WE_LO]) lo_d = hl_wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
